// File: rtl/needs_monitor.sv
// Per-need hysteresis status with debounce, sticky death detection and an
// alert queue that offers newly raised needs over a valid/ready handshake.
module needs_monitor #(
    parameter int unsigned N_NEEDS      = 6,
    parameter int unsigned LEVEL_W      = 4,
    parameter int unsigned SET_TH       = 12,
    parameter int unsigned CLR_TH       = 8,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned DEATH_CH     = 0,
    parameter int unsigned DEATH_CYCLES = 8,
    localparam int unsigned ID_W        = $clog2(N_NEEDS),
    localparam int unsigned NC_W        = $clog2(N_NEEDS + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         enable_i,
    input  logic [N_NEEDS*LEVEL_W-1:0]   levels_i,
    output logic [N_NEEDS-1:0]           status_o,
    output logic [NC_W-1:0]              need_count_o,
    output logic                         dead_o,
    output logic                         alert_valid_o,
    output logic [ID_W-1:0]              alert_id_o,
    input  logic                         alert_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned DC_W  = $clog2(DEATH_CYCLES + 1);
    localparam logic [0:0]  ST_OFF = 1'b0;
    localparam logic [0:0]  ST_ON  = 1'b1;

    logic [N_NEEDS-1:0] status_q, status_d;
    logic [N_NEEDS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q [N_NEEDS];
    logic [CNT_W-1:0]   cnt_d [N_NEEDS];
    logic [DC_W-1:0]    dc_q, dc_d;
    logic               dead_q, dead_d;
    logic               alert_valid_q, alert_valid_d;
    logic [ID_W-1:0]    alert_id_q, alert_id_d;
    logic [LEVEL_W-1:0] lvl [N_NEEDS];
    logic [N_NEEDS-1:0] sel_mask;
    logic [ID_W-1:0]    sel_id;
    logic               sel_hit;
    logic               cond;

    always_comb begin
        for (int i = 0; i < N_NEEDS; i++) begin
            lvl[i] = levels_i[i*LEVEL_W +: LEVEL_W];
        end
    end

    // Hysteresis/debounce per channel plus the death counter; all frozen once dead.
    always_comb begin
        status_d = status_q;
        dc_d     = dc_q;
        dead_d   = dead_q;
        cond     = 1'b0;
        for (int i = 0; i < N_NEEDS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (dead_q) begin
            status_d = '1;
        end else if (enable_i) begin
            for (int i = 0; i < N_NEEDS; i++) begin
                if (status_q[i] == ST_OFF) begin
                    cond = (lvl[i] >= LEVEL_W'(SET_TH));
                end else begin
                    cond = (lvl[i] <= LEVEL_W'(CLR_TH));
                end
                if (!cond) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    cnt_d[i]    = '0;
                    status_d[i] = (status_q[i] == ST_OFF) ? ST_ON : ST_OFF;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (lvl[DEATH_CH] == '1) begin
                dc_d = dc_q + DC_W'(1);
                if (dc_d == DC_W'(DEATH_CYCLES)) begin
                    dead_d   = 1'b1;
                    status_d = '1;
                end
            end else begin
                dc_d = '0;
            end
        end
    end

    // Lowest-index pending need wins the next alert slot.
    always_comb begin
        sel_hit  = 1'b0;
        sel_id   = '0;
        sel_mask = '0;
        for (int i = N_NEEDS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_hit     = 1'b1;
                sel_id      = ID_W'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

    // A rise on the same edge as a load re-arms the pending bit.
    always_comb begin
        pending_d     = pending_q;
        alert_valid_d = alert_valid_q;
        alert_id_d    = alert_id_q;
        if (dead_q) begin
            pending_d     = '0;
            alert_valid_d = 1'b0;
        end else begin
            if (!alert_valid_q || alert_ready_i) begin
                if (sel_hit) begin
                    alert_valid_d = 1'b1;
                    alert_id_d    = sel_id;
                    pending_d     = pending_q & ~sel_mask;
                end else begin
                    alert_valid_d = 1'b0;
                end
            end
            pending_d = pending_d | (status_d & ~status_q);
            if (dead_d) begin
                pending_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            status_q      <= '0;
            pending_q     <= '0;
            dc_q          <= '0;
            dead_q        <= 1'b0;
            alert_valid_q <= 1'b0;
            alert_id_q    <= '0;
            for (int i = 0; i < N_NEEDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            status_q      <= status_d;
            pending_q     <= pending_d;
            dc_q          <= dc_d;
            dead_q        <= dead_d;
            alert_valid_q <= alert_valid_d;
            alert_id_q    <= alert_id_d;
            for (int i = 0; i < N_NEEDS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        need_count_o = '0;
        for (int i = 0; i < N_NEEDS; i++) begin
            need_count_o = need_count_o + NC_W'(status_q[i]);
        end
    end

    assign status_o      = status_q;
    assign dead_o        = dead_q;
    assign alert_valid_o = alert_valid_q;
    assign alert_id_o    = alert_id_q;

endmodule

// File: tb/tb_needs_monitor.sv
// Directed bench for needs_monitor: status/death checks inline, alert ids
// checked by a scoreboard monitor at every accepted handshake.
module tb_needs_monitor;

    localparam int unsigned N  = 6;
    localparam int unsigned LW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [N*LW-1:0] levels;
    logic [N-1:0]    status;
    logic [2:0]      need_count;
    logic            dead;
    logic            alert_valid;
    logic [2:0]      alert_id;
    logic            alert_ready;

    int total = 0;
    int bad   = 0;
    int exp_q [$];

    needs_monitor dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .enable_i      (enable),
        .levels_i      (levels),
        .status_o      (status),
        .need_count_o  (need_count),
        .dead_o        (dead),
        .alert_valid_o (alert_valid),
        .alert_id_o    (alert_id),
        .alert_ready_i (alert_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lvl(input int ch, input logic [LW-1:0] v);
        levels[ch*LW +: LW] = v;
    endtask

    // Scoreboard monitor: every accepted alert must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && alert_valid && alert_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL alert_unexpected got=%0d exp=none", alert_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(alert_id) != e) begin
                    bad++;
                    $display("FAIL alert_id got=%0d exp=%0d", alert_id, e);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        levels      = '0;
        alert_ready = 1'b0;
        #3;
        check("rst_status", 32'(status), 0);
        check("rst_valid", 32'(alert_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle levels
        step(20);
        check("idle_status", 32'(status), 0);
        check("idle_dead", 32'(dead), 0);
        check("idle_valid", 32'(alert_valid), 0);
        check("idle_count", 32'(need_count), 0);

        // Channel 2 rise with an interrupted count
        alert_ready = 1'b1;
        set_lvl(2, 12);
        step(3);
        set_lvl(2, 11);
        step(1);
        set_lvl(2, 12);
        exp_q.push_back(2);
        step(3);
        check("ch2_restart", 32'(status[2]), 0);
        step(1);
        check("ch2_set", 32'(status[2]), 1);
        check("ch2_count", 32'(need_count), 1);
        step(3);

        // Hysteresis band and clear with a glitch
        set_lvl(2, 10);
        step(10);
        check("ch2_band_hold", 32'(status[2]), 1);
        set_lvl(2, 8);
        step(3);
        set_lvl(2, 9);
        step(1);
        set_lvl(2, 8);
        step(3);
        check("ch2_glitch_hold", 32'(status[2]), 1);
        step(1);
        check("ch2_clear", 32'(status[2]), 0);
        set_lvl(2, 0);
        alert_ready = 1'b0;

        // Two channels rising together, id held while not ready
        set_lvl(4, 12);
        set_lvl(1, 12);
        exp_q.push_back(1);
        exp_q.push_back(4);
        step(4);
        check("dual_status", 32'(status), 32'h12);
        check("dual_count", 32'(need_count), 2);
        step(1);
        check("dual_valid", 32'(alert_valid), 1);
        check("dual_id_first", 32'(alert_id), 1);
        step(3);
        check("dual_id_hold", 32'(alert_id), 1);
        alert_ready = 1'b1;
        step(1);
        alert_ready = 1'b0;
        check("dual_valid2", 32'(alert_valid), 1);
        check("dual_id_second", 32'(alert_id), 4);
        alert_ready = 1'b1;
        step(1);
        alert_ready = 1'b0;
        check("dual_drained", 32'(alert_valid), 0);
        set_lvl(1, 0);
        set_lvl(4, 0);
        step(4);
        check("dual_cleared", 32'(status), 0);

        // Enable low freezes status; handshake still completes
        set_lvl(5, 12);
        exp_q.push_back(5);
        step(5);
        check("en_pre_valid", 32'(alert_valid), 1);
        enable = 1'b0;
        set_lvl(3, 13);
        step(10);
        check("en_frozen_ch3", 32'(status[3]), 0);
        check("en_frozen_ch5", 32'(status[5]), 1);
        check("en_alert_held", 32'(alert_id), 5);
        alert_ready = 1'b1;
        step(1);
        alert_ready = 1'b0;
        check("en_alert_done", 32'(alert_valid), 0);
        enable = 1'b1;
        exp_q.push_back(3);
        step(3);
        check("en_resume_wait", 32'(status[3]), 0);
        step(1);
        check("en_resume_set", 32'(status[3]), 1);
        alert_ready = 1'b1;
        step(2);
        set_lvl(3, 0);
        set_lvl(5, 0);
        step(4);
        check("en_cleared", 32'(status), 0);

        // Death: 7 saturated cycles then a break, then 8 saturated cycles
        set_lvl(0, 15);
        exp_q.push_back(0);
        step(7);
        set_lvl(0, 14);
        step(1);
        check("death_not_yet", 32'(dead), 0);
        set_lvl(0, 15);
        step(7);
        check("death_7", 32'(dead), 0);
        step(1);
        check("death_dead", 32'(dead), 1);
        check("death_status", 32'(status), 32'h3f);
        check("death_count", 32'(need_count), 6);
        step(1);
        check("death_valid", 32'(alert_valid), 0);
        levels = '0;
        step(10);
        check("death_sticky", 32'(dead), 1);
        check("death_status_hold", 32'(status), 32'h3f);

        // Async reset clears death
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_dead", 32'(dead), 0);
        check("rst_status2", 32'(status), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-handshake and mid-count drops everything
        alert_ready = 1'b0;
        set_lvl(2, 12);
        step(5);
        check("mid_valid", 32'(alert_valid), 1);
        check("mid_id", 32'(alert_id), 2);
        set_lvl(3, 12);
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(alert_valid), 0);
        check("mid_rst_status", 32'(status), 0);
        check("mid_rst_count", 32'(need_count), 0);
        levels = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step(6);
        check("post_rst_valid", 32'(alert_valid), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
